// File: rtl/fib_stream_pkg.sv
// Shared types and constants for the Fibonacci stream generator.
// The state encoding, overflow policy selectors and reset seeds live here.
// This keeps the top module and any checker in agreement.
package fib_stream_pkg;

  // Generator FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Overflow policy selectors for the OVF_MODE parameter
  localparam int unsigned OVF_STOP = 0;
  localparam int unsigned OVF_WRAP = 1;

  // Seeds loaded by the asynchronous reset (classic 0, 1 Fibonacci)
  localparam int unsigned RST_A = 0;
  localparam int unsigned RST_B = 1;

endpackage : fib_stream_pkg

// File: rtl/fib_step.sv
// Combinational Fibonacci step.
// Forms the term after b as a WIDTH+1-bit sum of a and b.
// The overflow flag is sticky along the chain: once any operand's true value
// exceeded WIDTH bits, every later term does too, even if the truncated sum
// happens not to carry.
module fib_step
  import fib_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_a_c,
  input  logic             i_b_c,
  output logic [WIDTH-1:0] o_next_b,
  output logic             o_next_b_c
);

  logic [WIDTH:0] w_sum;

  // Full-width add; the extra bit is the carry out of the WIDTH-bit term
  always_comb begin
    w_sum      = {1'b0, i_a} + {1'b0, i_b};
    o_next_b   = w_sum[WIDTH-1:0];
    o_next_b_c = w_sum[WIDTH] | i_a_c | i_b_c;
  end

endmodule : fib_step

// File: rtl/fib_stream_gen.sv
// Generalised Fibonacci producer with a valid/ready output handshake.
// Register a holds the term on offer and b holds the next one. The a_c/b_c
// bits record that the true value no longer fits in WIDTH bits.
// A term that has been offered is held until accepted, so back-pressure never
// drops or repeats a term. A restart pulse is the only way to withdraw an
// offer.
module fib_stream_gen
  import fib_stream_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int IDX_W    = 8,
  parameter int OVF_MODE = 0
) (
  input  logic             clock_1,
  input  logic             reset,
  input  logic             f_en,
  input  logic             restart,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic             f_ready,
  output logic             f_valid,
  output logic [WIDTH-1:0] f_out,
  output logic [IDX_W-1:0] f_index,
  output logic             f_ovf,
  output logic             f_done
);

  // Stop policy: halt before offering the first term that does not fit
  localparam logic STOP_MODE = (OVF_MODE == int'(OVF_STOP)) ? 1'b1 : 1'b0;
  localparam logic [WIDTH-1:0] SEED_A_RST = WIDTH'(RST_A);
  localparam logic [WIDTH-1:0] SEED_B_RST = WIDTH'(RST_B);

  // State registers
  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_a_c;
  logic             r_b_c;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic             r_done;
  logic             r_ovf;

  // Next-state values
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic             w_a_c_nxt;
  logic             w_b_c_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_valid_nxt;
  logic             w_done_nxt;
  logic             w_ovf_nxt;

  // Step outputs and handshake
  logic [WIDTH-1:0] w_step_b;
  logic             w_step_b_c;
  logic             w_accept;

  fib_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a        (r_a),
    .i_b        (r_b),
    .i_a_c      (r_a_c),
    .i_b_c      (r_b_c),
    .o_next_b   (w_step_b),
    .o_next_b_c (w_step_b_c)
  );

  // A transfer happens only when a term is on offer and the consumer takes it
  always_comb begin
    w_accept = r_valid & f_ready;
  end

  // Next-state logic: restart first, then the FSM with its handshake rules
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_a_c_nxt   = r_a_c;
    w_b_c_nxt   = r_b_c;
    w_idx_nxt   = r_idx;
    w_ovf_nxt   = r_ovf;

    if (restart) begin
      // Reload from seeds; any pending offer is withdrawn and nothing is counted
      w_state_nxt = ST_IDLE;
      w_a_nxt     = seed_a;
      w_b_nxt     = seed_b;
      w_a_c_nxt   = 1'b0;
      w_b_c_nxt   = 1'b0;
      w_idx_nxt   = {IDX_W{1'b0}};
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (f_en) begin
            // In stop mode a term that overflowed is never offered
            if (r_a_c && STOP_MODE) begin
              w_state_nxt = ST_DONE;
              w_ovf_nxt   = 1'b1;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            w_a_nxt   = r_b;
            w_a_c_nxt = r_b_c;
            w_b_nxt   = w_step_b;
            w_b_c_nxt = w_step_b_c;
            w_idx_nxt = r_idx + IDX_W'(1);
            // Wrap mode: flag once a truncated term has actually been delivered
            if (r_a_c) begin
              w_ovf_nxt = 1'b1;
            end else begin
              w_ovf_nxt = r_ovf;
            end
            // f_en is only consulted after the accept, never mid-offer
            if (r_b_c && STOP_MODE) begin
              w_state_nxt = ST_DONE;
              w_ovf_nxt   = 1'b1;
            end else if (f_en) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
          w_ovf_nxt   = 1'b1;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    w_valid_nxt = (w_state_nxt == ST_RUN)  ? 1'b1 : 1'b0;
    w_done_nxt  = (w_state_nxt == ST_DONE) ? 1'b1 : 1'b0;
  end

  // State and output registers; asynchronous reset to the 0, 1 sequence
  always_ff @(posedge clock_1 or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_a     <= SEED_A_RST;
      r_b     <= SEED_B_RST;
      r_a_c   <= 1'b0;
      r_b_c   <= 1'b0;
      r_idx   <= {IDX_W{1'b0}};
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_a_c   <= w_a_c_nxt;
      r_b_c   <= w_b_c_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    f_valid = r_valid;
    f_out   = r_a;
    f_index = r_idx;
    f_ovf   = r_ovf;
    f_done  = r_done;
  end

endmodule : fib_stream_gen

// File: tb/tb_fib_stream_gen.sv
// Directed testbench for fib_stream_gen.
// Both overflow policies are instantiated side by side and share all inputs.
module tb_fib_stream_gen;

  logic        clock_1;
  logic        reset;
  logic        f_en;
  logic        restart;
  logic [15:0] seed_a;
  logic [15:0] seed_b;
  logic        f_ready;

  logic        s_valid, s_ovf, s_done;
  logic [15:0] s_out;
  logic [7:0]  s_idx;
  logic        w_valid, w_ovf, w_done;
  logic [15:0] w_out;
  logic [7:0]  w_idx;

  int checks = 0;
  int errors = 0;

  fib_stream_gen #(.WIDTH(16), .IDX_W(8), .OVF_MODE(0)) u_stop (
    .clock_1 (clock_1), .reset (reset), .f_en (f_en), .restart (restart),
    .seed_a (seed_a), .seed_b (seed_b), .f_ready (f_ready),
    .f_valid (s_valid), .f_out (s_out), .f_index (s_idx),
    .f_ovf (s_ovf), .f_done (s_done)
  );

  fib_stream_gen #(.WIDTH(16), .IDX_W(8), .OVF_MODE(1)) u_wrap (
    .clock_1 (clock_1), .reset (reset), .f_en (f_en), .restart (restart),
    .seed_a (seed_a), .seed_b (seed_b), .f_ready (f_ready),
    .f_valid (w_valid), .f_out (w_out), .f_index (w_idx),
    .f_ovf (w_ovf), .f_done (w_done)
  );

  // 10 ns clock
  initial clock_1 = 1'b0;
  always #5 clock_1 = ~clock_1;

  // Advance one rising edge and settle before sampling/driving
  task automatic tick();
    @(posedge clock_1);
    #1;
  endtask

  // Restart both generators with the given seeds, leaving them idle
  task automatic do_restart(input logic [15:0] sa, input logic [15:0] sb);
    seed_a  = sa;
    seed_b  = sb;
    restart = 1'b1;
    f_en    = 1'b0;
    f_ready = 1'b0;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (s_valid !== 1'b0 || s_out !== 16'd0 || s_idx !== 8'd0 || s_ovf !== 1'b0 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_stop: got v=%0b out=%0d idx=%0d ovf=%0b done=%0b expected 0 0 0 0 0",
               s_valid, s_out, s_idx, s_ovf, s_done);
    end
    checks++;
    if (w_valid !== 1'b0 || w_out !== 16'd0 || w_idx !== 8'd0 || w_ovf !== 1'b0 || w_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrap: got v=%0b out=%0d idx=%0d ovf=%0b done=%0b expected 0 0 0 0 0",
               w_valid, w_out, w_idx, w_ovf, w_done);
    end
    #4;
    reset = 1'b1;
  endtask

  task automatic test_stream();
    logic [15:0] exp_seq [0:7];
    exp_seq = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13};
    f_en    = 1'b1;
    f_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_out !== exp_seq[i] || s_idx !== 8'(i)) begin
        errors++;
        $display("FAIL stream[%0d]: got v=%0b out=%0d idx=%0d expected v=1 out=%0d idx=%0d",
                 i, s_valid, s_out, s_idx, exp_seq[i], i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_seq [0:5];
    exp_seq = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5};
    do_restart(16'd0, 16'd1);
    checks++;
    if (s_valid !== 1'b0 || s_out !== 16'd0 || s_idx !== 8'd0) begin
      errors++;
      $display("FAIL restart_clear: got v=%0b out=%0d idx=%0d expected v=0 out=0 idx=0", s_valid, s_out, s_idx);
    end
    f_en    = 1'b1;
    f_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) f_ready = 1'b0;
      checks++;
      if (s_out !== exp_seq[i] || s_idx !== 8'(i)) begin
        errors++;
        $display("FAIL bp_lead[%0d]: got out=%0d idx=%0d expected out=%0d idx=%0d", i, s_out, s_idx, exp_seq[i], i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_out !== 16'd5 || s_idx !== 8'd5) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%0b out=%0d idx=%0d expected v=1 out=5 idx=5", i, s_valid, s_out, s_idx);
      end
    end
    f_ready = 1'b1;
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_out !== 16'd8 || s_idx !== 8'd6) begin
      errors++;
      $display("FAIL bp_next: got v=%0b out=%0d idx=%0d expected v=1 out=8 idx=6", s_valid, s_out, s_idx);
    end
  endtask

  task automatic test_en_drop();
    tick();
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_out !== 16'd21 || s_idx !== 8'd8) begin
      errors++;
      $display("FAIL en_lead: got v=%0b out=%0d idx=%0d expected v=1 out=21 idx=8", s_valid, s_out, s_idx);
    end
    f_ready = 1'b0;
    f_en    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_out !== 16'd21 || s_idx !== 8'd8) begin
        errors++;
        $display("FAIL en_hold[%0d]: got v=%0b out=%0d idx=%0d expected v=1 out=21 idx=8", i, s_valid, s_out, s_idx);
      end
    end
    f_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_out !== 16'd34 || s_idx !== 8'd9) begin
      errors++;
      $display("FAIL en_idle: got v=%0b out=%0d idx=%0d expected v=0 out=34 idx=9", s_valid, s_out, s_idx);
    end
    f_en = 1'b1;
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_out !== 16'd34 || s_idx !== 8'd9) begin
      errors++;
      $display("FAIL en_resume: got v=%0b out=%0d idx=%0d expected v=1 out=34 idx=9", s_valid, s_out, s_idx);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] fa, fb, ft;
    do_restart(16'd0, 16'd1);
    f_en    = 1'b1;
    f_ready = 1'b1;
    fa = 32'd0;
    fb = 32'd1;
    for (int k = 0; k <= 24; k++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_out !== fa[15:0] || s_idx !== 8'(k) || s_ovf !== 1'b0 ||
          w_valid !== 1'b1 || w_out !== fa[15:0] || w_idx !== 8'(k) || w_ovf !== 1'b0) begin
        errors++;
        $display("FAIL long_run[%0d]: got stop=%0d/%0d wrap=%0d/%0d ovf=%0b%0b expected %0d/%0d no ovf",
                 k, s_out, s_idx, w_out, w_idx, s_ovf, w_ovf, fa, k);
      end
      ft = fa + fb;
      fa = fb;
      fb = ft;
    end
    checks++;
    if (s_out !== 16'd46368 || s_idx !== 8'd24) begin
      errors++;
      $display("FAIL stop_last: got out=%0d idx=%0d expected out=46368 idx=24", s_out, s_idx);
    end
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_done !== 1'b1 || s_ovf !== 1'b1) begin
      errors++;
      $display("FAIL stop_done: got v=%0b done=%0b ovf=%0b expected v=0 done=1 ovf=1", s_valid, s_done, s_ovf);
    end
    checks++;
    if (w_valid !== 1'b1 || w_out !== 16'd9489 || w_idx !== 8'd25 || w_ovf !== 1'b0 || w_done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_25: got v=%0b out=%0d idx=%0d ovf=%0b done=%0b expected v=1 out=9489 idx=25 ovf=0 done=0",
               w_valid, w_out, w_idx, w_ovf, w_done);
    end
    tick();
    checks++;
    if (w_valid !== 1'b1 || w_out !== 16'd55857 || w_idx !== 8'd26 || w_ovf !== 1'b1) begin
      errors++;
      $display("FAIL wrap_26: got v=%0b out=%0d idx=%0d ovf=%0b expected v=1 out=55857 idx=26 ovf=1",
               w_valid, w_out, w_idx, w_ovf);
    end
    tick();
    checks++;
    if (w_valid !== 1'b1 || w_out !== 16'd65346 || w_idx !== 8'd27 || w_ovf !== 1'b1) begin
      errors++;
      $display("FAIL wrap_27: got v=%0b out=%0d idx=%0d ovf=%0b expected v=1 out=65346 idx=27 ovf=1",
               w_valid, w_out, w_idx, w_ovf);
    end
    checks++;
    if (s_valid !== 1'b0 || s_done !== 1'b1 || s_idx !== 8'd25) begin
      errors++;
      $display("FAIL stop_stays: got v=%0b done=%0b idx=%0d expected v=0 done=1 idx=25", s_valid, s_done, s_idx);
    end
  endtask

  task automatic test_restart_reset();
    logic [15:0] lucas [0:5];
    lucas = '{16'd2, 16'd1, 16'd3, 16'd4, 16'd7, 16'd11};
    // Restart with handshake inputs high: restart wins, nothing counted
    seed_a  = 16'd2;
    seed_b  = 16'd1;
    restart = 1'b1;
    f_en    = 1'b1;
    f_ready = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if (s_valid !== 1'b0 || s_out !== 16'd2 || s_idx !== 8'd0 || s_ovf !== 1'b0 || s_done !== 1'b0 ||
        w_valid !== 1'b0 || w_idx !== 8'd0 || w_ovf !== 1'b0) begin
      errors++;
      $display("FAIL restart_mid: got s v=%0b out=%0d idx=%0d ovf=%0b done=%0b w v=%0b idx=%0d ovf=%0b expected idle out=2 idx=0 flags 0",
               s_valid, s_out, s_idx, s_ovf, s_done, w_valid, w_idx, w_ovf);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_out !== lucas[i] || s_idx !== 8'(i) || w_out !== lucas[i]) begin
        errors++;
        $display("FAIL lucas[%0d]: got v=%0b out=%0d idx=%0d wrap_out=%0d expected v=1 out=%0d idx=%0d",
                 i, s_valid, s_out, s_idx, w_out, lucas[i], i);
      end
    end
    // Asynchronous reset between edges while RUN
    reset = 1'b0;
    #1;
    checks++;
    if (s_valid !== 1'b0 || s_out !== 16'd0 || s_idx !== 8'd0 || s_ovf !== 1'b0 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%0b out=%0d idx=%0d ovf=%0b done=%0b expected all 0",
               s_valid, s_out, s_idx, s_ovf, s_done);
    end
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_out !== ((i == 0) ? 16'd0 : 16'd1) || s_idx !== 8'(i)) begin
        errors++;
        $display("FAIL post_reset[%0d]: got v=%0b out=%0d idx=%0d expected v=1 out=%0d idx=%0d",
                 i, s_valid, s_out, s_idx, (i == 0) ? 0 : 1, i);
      end
    end
  endtask

  task automatic test_zero_seeds();
    do_restart(16'd0, 16'd0);
    f_en    = 1'b1;
    f_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    checks++;
    if (s_valid !== 1'b1 || s_out !== 16'd0 || s_idx !== 8'd4 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_seeds: got v=%0b out=%0d idx=%0d done=%0b expected v=1 out=0 idx=4 done=0",
               s_valid, s_out, s_idx, s_done);
    end
  endtask

  // Test sequence
  initial begin
    reset   = 1'b0;
    f_en    = 1'b0;
    restart = 1'b0;
    f_ready = 1'b0;
    seed_a  = 16'd0;
    seed_b  = 16'd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_en_drop();
    test_overflow();
    test_restart_reset();
    test_zero_seeds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fib_stream_gen
